// File: rtl/flippybit_pkg.sv
// Shared FlippyBit definitions: scheduler state encoding, lane count, LFSR
// polynomial and default timing constants (also used by the lane datapath).
// Helper lfsr_next() gives one step of the 8-bit Galois LFSR.
package flippybit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } fb_state_e;

  localparam int unsigned LANES          = 3;
  localparam logic [7:0]  LFSR_TAPS      = 8'hB8;

  localparam int unsigned TICK_BASE_DFLT = 25_000_000;  // 0.5 s @ 50 MHz
  localparam int unsigned TICK_MIN_DFLT  = 2_500_000;
  localparam int unsigned TICK_DEC_DFLT  = 1_500_000;
  localparam int unsigned PW_DFLT        = 25;
  localparam int unsigned LEVEL_SH_DFLT  = 3;
  localparam int unsigned SPAWN_GAP_DFLT = 4;
  localparam logic [7:0]  LFSR_SEED_DFLT = 8'hA5;

  // Right-shifting Galois step; taps B8 give the maximal 255-state cycle,
  // so a nonzero seed never reaches 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {1'b0, s[7:1]} ^ (s[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/lane_rr_arbiter.sv
// Three-way round-robin arbiter for spawn placement.
// Ports:
//   req      in  LANES  lane i is free and may take a spawn
//   ptr      in  2      lane searched first
//   advance  in  1      a spawn attempt happens this cycle
//   grant    out LANES  one-hot winner (0 if no request or no attempt)
//   next_ptr out 2      lane after the winner, or ptr unchanged when no grant
module lane_rr_arbiter
  import flippybit_pkg::*;
(
  input  logic [LANES-1:0] req,
  input  logic [1:0]       ptr,
  input  logic             advance,
  output logic [LANES-1:0] grant,
  output logic [1:0]       next_ptr
);

  logic [2:0] idx;
  logic       found;

  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      // search ptr, ptr+1, ... wrapping 2 -> 0
      idx = {1'b0, ptr} + 3'(k);
      if (idx >= 3'(LANES)) idx = idx - 3'(LANES);
      if (advance && !found && req[idx[1:0]]) begin
        found           = 1'b1;
        grant[idx[1:0]] = 1'b1;
        next_ptr        = (idx[1:0] == 2'(LANES - 1)) ? 2'd0 : idx[1:0] + 2'd1;
      end
    end
  end

endmodule

// File: rtl/lane_spawn_scheduler.sv
// Paces the three FlippyBit lanes: generates the fall-step tick (period
// shrinking with score-derived level) and places new targets into free
// lanes round-robin, with an LFSR-derived target pattern.
// Ports:
//   clock, reset_button  clock; asynchronous active-high reset
//   game_reset           synchronous clear from the game FSM (highest priority)
//   score[7:0]           current score, drives level
//   game_over_any        any lane reports game over -> HOLD
//   lane_busy[2:0]       lane cannot accept a spawn
//   step_tick            one-cycle pulse, all lanes advance a row
//   spawn[2:0]           one-hot load strobe, coincident with step_tick
//   spawn_value[7:0]     pattern for the spawned lane
//   level[3:0]           min(score >> LEVEL_SHIFT, 15)
//   running              high while in RUN
module lane_spawn_scheduler
  import flippybit_pkg::*;
#(
  parameter int unsigned TICK_BASE   = TICK_BASE_DFLT,
  parameter int unsigned TICK_MIN    = TICK_MIN_DFLT,
  parameter int unsigned TICK_DEC    = TICK_DEC_DFLT,
  parameter int unsigned PW          = PW_DFLT,
  parameter int unsigned LEVEL_SHIFT = LEVEL_SH_DFLT,
  parameter int unsigned SPAWN_GAP   = SPAWN_GAP_DFLT,
  parameter logic [7:0]  LFSR_SEED   = LFSR_SEED_DFLT
)(
  input  logic             clock,
  input  logic             reset_button,
  input  logic             game_reset,
  input  logic [7:0]       score,
  input  logic             game_over_any,
  input  logic [LANES-1:0] lane_busy,
  output logic             step_tick,
  output logic [LANES-1:0] spawn,
  output logic [7:0]       spawn_value,
  output logic [3:0]       level,
  output logic             running
);

  localparam int unsigned PCW = PW + 4;
  localparam int unsigned GW  = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;

  localparam logic [PCW-1:0] BASE_W   = PCW'(TICK_BASE);
  localparam logic [PCW-1:0] MIN_W    = PCW'(TICK_MIN);
  localparam logic [PCW-1:0] DEC_W    = PCW'(TICK_DEC);
  localparam logic [PW-1:0]  PRESC_INIT = PW'(TICK_BASE - 1);
  localparam logic [GW-1:0]  GAP_LAST = GW'(SPAWN_GAP - 1);

  fb_state_e        state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic             step_tick_q, step_tick_d;
  logic [LANES-1:0] spawn_q, spawn_d;
  logic [7:0]       spawn_value_q, spawn_value_d;
  logic [3:0]       level_q, level_d;
  logic             running_q, running_d;

  logic [7:0]       lvl_raw;
  logic [PCW-1:0]   dec_amt, period;
  logic [PW-1:0]    reload;
  logic             try_spawn;
  logic [LANES-1:0] grant;
  logic [1:0]       rr_next_ptr;

  // Step period from the currently registered level; clamp is decided
  // before subtracting so the difference never wraps.
  always_comb begin
    lvl_raw = score >> LEVEL_SHIFT;
    level_d = (lvl_raw > 8'd15) ? 4'd15 : lvl_raw[3:0];
    dec_amt = DEC_W * {{(PCW-4){1'b0}}, level_q};
    period  = (dec_amt >= BASE_W - MIN_W) ? MIN_W : BASE_W - dec_amt;
    reload  = PW'(period - PCW'(1));
  end

  // Kept outside the main comb block so the arbiter loop-back stays acyclic.
  assign try_spawn = (state_q == ST_RUN) && !game_reset && !game_over_any &&
                     (presc_q == '0) && (gap_q == GAP_LAST);

  lane_rr_arbiter u_arb (
    .req      (~lane_busy),
    .ptr      (ptr_q),
    .advance  (try_spawn),
    .grant    (grant),
    .next_ptr (rr_next_ptr)
  );

  always_comb begin
    state_d       = state_q;
    presc_d       = presc_q;
    gap_d         = gap_q;
    ptr_d         = ptr_q;
    lfsr_d        = lfsr_q;
    step_tick_d   = 1'b0;
    spawn_d       = '0;
    spawn_value_d = spawn_value_q;

    if (game_reset || state_q == ST_IDLE) begin
      // IDLE keeps everything at its reset value; leaves on first quiet cycle
      state_d       = game_reset ? ST_IDLE : ST_RUN;
      presc_d       = PRESC_INIT;
      gap_d         = '0;
      ptr_d         = '0;
      lfsr_d        = LFSR_SEED;
      spawn_value_d = '0;
    end else if (state_q == ST_RUN) begin
      if (game_over_any) begin
        // a coincident expiry is dropped: no tick, no spawn, counters frozen
        state_d = ST_HOLD;
      end else begin
        lfsr_d = lfsr_next(lfsr_q);
        if (presc_q == '0) begin
          step_tick_d = 1'b1;
          presc_d     = reload;
          if (gap_q == GAP_LAST) begin
            // no free lane: counter stays at GAP_LAST, retry next tick
            if (|grant) begin
              spawn_d       = grant;
              ptr_d         = rr_next_ptr;
              gap_d         = '0;
              spawn_value_d = lfsr_q;
            end
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end else begin
          presc_d = presc_q - PW'(1);
        end
      end
    end
    // ST_HOLD: everything frozen until game_reset

    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clock or posedge reset_button) begin
    if (reset_button) begin
      state_q       <= ST_IDLE;
      presc_q       <= PRESC_INIT;
      gap_q         <= '0;
      ptr_q         <= '0;
      lfsr_q        <= LFSR_SEED;
      step_tick_q   <= 1'b0;
      spawn_q       <= '0;
      spawn_value_q <= '0;
      level_q       <= '0;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      gap_q         <= gap_d;
      ptr_q         <= ptr_d;
      lfsr_q        <= lfsr_d;
      step_tick_q   <= step_tick_d;
      spawn_q       <= spawn_d;
      spawn_value_q <= spawn_value_d;
      level_q       <= level_d;
      running_q     <= running_d;
    end
  end

  assign step_tick   = step_tick_q;
  assign spawn       = spawn_q;
  assign spawn_value = spawn_value_q;
  assign level       = level_q;
  assign running     = running_q;

endmodule

// File: tb/tb_lane_spawn_scheduler.sv
// Directed + randomized bench for lane_spawn_scheduler, checked against a
// behavioural model of the pacing/spawn rules.
module tb_lane_spawn_scheduler;

  localparam int TB = 20, TMIN = 4, TDEC = 4, SG = 2;

  logic       clock = 1'b0;
  logic       reset_button, game_reset, game_over_any;
  logic [7:0] score;
  logic [2:0] lane_busy;
  logic       step_tick, running;
  logic [2:0] spawn;
  logic [7:0] spawn_value;
  logic [3:0] level;

  always #5 clock = ~clock;

  lane_spawn_scheduler #(
    .TICK_BASE(TB), .TICK_MIN(TMIN), .TICK_DEC(TDEC), .PW(25),
    .LEVEL_SHIFT(3), .SPAWN_GAP(SG), .LFSR_SEED(8'hA5)
  ) dut (
    .clock(clock), .reset_button(reset_button), .game_reset(game_reset),
    .score(score), .game_over_any(game_over_any), .lane_busy(lane_busy),
    .step_tick(step_tick), .spawn(spawn), .spawn_value(spawn_value),
    .level(level), .running(running)
  );

  int n_pass = 0, n_total = 0, n_fail = 0;

  // model: m_st 0=idle 1=run 2=hold; m_left = cycles until next expiry
  int         m_st, m_left, m_gap, m_ptr, m_level;
  logic [7:0] m_lfsr;
  logic       e_tick, e_run;
  logic [2:0] e_spawn;
  logic [7:0] e_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_adv(input logic [7:0] s);
    logic [7:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 8'hB8;
    return n;
  endfunction

  function automatic int period_of(input int lv);
    int p;
    p = TB - lv * TDEC;
    return (p < TMIN) ? TMIN : p;
  endfunction

  task automatic model_reset();
    m_st = 0; m_left = TB - 1; m_gap = 0; m_ptr = 0; m_level = 0;
    m_lfsr = 8'hA5; e_tick = 0; e_spawn = 0; e_val = 0; e_run = 0;
  endtask

  task automatic model_edge();
    int         lv_old;
    logic [7:0] lf_old;
    lv_old  = m_level;
    e_tick  = 0;
    e_spawn = 0;
    m_level = ((score >> 3) > 15) ? 15 : int'(score >> 3);
    if (game_reset || m_st == 0) begin
      m_st = game_reset ? 0 : 1;
      m_left = TB - 1; m_gap = 0; m_ptr = 0; m_lfsr = 8'hA5; e_val = 0;
    end else if (m_st == 1) begin
      if (game_over_any) m_st = 2;
      else begin
        lf_old = m_lfsr;
        m_lfsr = lfsr_adv(m_lfsr);
        if (m_left == 0) begin
          e_tick = 1;
          m_left = period_of(lv_old) - 1;
          if (m_gap == SG - 1) begin
            for (int k = 0; k < 3; k++) begin
              int ln;
              ln = (m_ptr + k) % 3;
              if (e_spawn == 0 && !lane_busy[ln]) begin
                e_spawn = 3'b001 << ln;
                m_ptr = (ln + 1) % 3;
                m_gap = 0;
                e_val = lf_old;
              end
            end
          end else m_gap++;
        end else m_left--;
      end
    end
    e_run = (m_st == 1);
  endtask

  task automatic step();
    @(posedge clock);
    if (reset_button) model_reset(); else model_edge();
    #1;
    chk("step_tick", 32'(step_tick), 32'(e_tick));
    chk("spawn", 32'(spawn), 32'(e_spawn));
    chk("spawn_value", 32'(spawn_value), 32'(e_val));
    chk("level", 32'(level), 32'(m_level));
    chk("running", 32'(running), 32'(e_run));
  endtask

  // n = cycles until step_tick is seen, -1 if the budget runs out
  task automatic wait_tick(input int budget, output int n, output logic [2:0] sp);
    n = 0; sp = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      n++;
      if (step_tick) begin
        sp = spawn;
        return;
      end
    end
    n = -1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tick"}, 32'(step_tick), 0);
    chk({tag, "_spawn"}, 32'(spawn), 0);
    chk({tag, "_value"}, 32'(spawn_value), 0);
    chk({tag, "_level"}, 32'(level), 0);
    chk({tag, "_running"}, 32'(running), 0);
  endtask

  logic [2:0] exp_sp8 [8] = '{3'b000, 3'b001, 3'b000, 3'b010,
                              3'b000, 3'b100, 3'b000, 3'b001};
  logic [2:0] exp_sp6 [6] = '{3'b000, 3'b100, 3'b000, 3'b000, 3'b000, 3'b010};

  initial begin
    int         n, nsp, nzero, cnt;
    logic [2:0] sp;

    reset_button = 1; game_reset = 0; game_over_any = 0; score = 0; lane_busy = 0;
    model_reset();
    #2;
    chk_all_zero("reset");
    repeat (3) step();
    reset_button = 0;
    step();
    chk("running_after_release", 32'(running), 1);

    // level 0: period 20, spawns on every second tick, rotating lanes
    for (int t = 0; t < 8; t++) begin
      wait_tick(100, n, sp);
      chk("interval_l0", n, 20);
      chk("spawn_seq", 32'(sp), 32'(exp_sp8[t]));
    end

    // level 2 takes effect from the next reload
    score = 16;
    wait_tick(100, n, sp); chk("interval_pre_l2", n, 20);
    wait_tick(100, n, sp); chk("interval_l2", n, 12);
    wait_tick(100, n, sp); chk("interval_l2b", n, 12);
    chk("level2", 32'(level), 2);
    score = 255;
    wait_tick(100, n, sp); chk("interval_pre_l15", n, 12);
    wait_tick(100, n, sp); chk("interval_l15", n, 4);
    wait_tick(100, n, sp); chk("interval_l15b", n, 4);
    chk("level15", 32'(level), 15);

    // restart with pointer at lane 0 and busy lanes
    lane_busy = 3'b011;
    game_reset = 1; step();
    game_reset = 0; step();
    chk("running_after_game_reset", 32'(running), 1);
    for (int t = 0; t < 6; t++) begin
      wait_tick(100, n, sp);
      chk("interval_busy", n, (t == 0) ? 20 : 4);
      chk("spawn_busy", 32'(sp), 32'(exp_sp6[t]));
      if (t == 1) lane_busy = 3'b111;
      if (t == 4) lane_busy = 3'b101;
    end

    // game over on the expiry cycle
    repeat (3) step();
    game_over_any = 1;
    step();
    chk("over_no_tick", 32'(step_tick), 0);
    chk("over_no_spawn", 32'(spawn), 0);
    chk("over_hold", 32'(running), 0);
    game_over_any = 0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (step_tick) cnt++;
    end
    chk("hold_ticks", cnt, 0);
    game_reset = 1; step();
    game_reset = 0; step();
    chk("running_after_hold", 32'(running), 1);
    wait_tick(100, n, sp); chk("interval_restart", n, 20);

    // randomized lane occupancy and score, 300 spawns
    nsp = 0; nzero = 0;
    for (int i = 0; i < 40000 && nsp < 300; i++) begin
      lane_busy = 3'($urandom) & 3'($urandom);
      if ($urandom_range(0, 199) == 0) score = 8'($urandom);
      step();
      if (spawn != 0) begin
        nsp++;
        if (spawn_value == 0) nzero++;
      end
    end
    chk("spawn_count", nsp, 300);
    chk("zero_values", nzero, 0);

    // asynchronous reset in the middle of RUN
    #3;
    reset_button = 1;
    #1;
    model_reset();
    chk_all_zero("async_reset");
    step();
    reset_button = 0;
    step();
    chk("running_after_async", 32'(running), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
